axi_stream_split_multi_channel: RTL and testbench

//  Splits each packet on one AXI-stream input into up to NUM consecutive segments, one per output

---
 rtl/axi_stream_split_multi_channel.sv | 102 ++++++++++
 tb/tb_axi_stream_split_multi_channel.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_split_multi_channel.sv
// Splits each AXI-stream packet into up to NUM consecutive segments, one per output channel.
// Zero-latency pass-through; a tlast is inserted at every segment boundary.
module axi_stream_split_multi_channel #(
    parameter int NUM   = 2,
    parameter int DSIZE = 8,
    parameter int KSIZE = 1,
    parameter int USIZE = 1,
    parameter int LSIZE = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NUM*LSIZE-1:0]   split_len,
    input  logic [DSIZE-1:0]       origin_tdata,
    input  logic [KSIZE-1:0]       origin_tkeep,
    input  logic [USIZE-1:0]       origin_tuser,
    input  logic                   origin_tvalid,
    input  logic                   origin_tlast,
    output logic                   origin_tready,
    output logic [NUM*DSIZE-1:0]   out_tdata,
    output logic [NUM*KSIZE-1:0]   out_tkeep,
    output logic [NUM*USIZE-1:0]   out_tuser,
    output logic [NUM-1:0]         out_tvalid,
    output logic [NUM-1:0]         out_tlast,
    input  logic [NUM-1:0]         out_tready,
    output logic                   short_pkt
);

    localparam int              CW      = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CW-1:0]   LAST_CH = CW'(NUM - 1);
    localparam logic [LSIZE-1:0] CNT_MAX = '1;

    function automatic logic [LSIZE-1:0] norm_len(input logic [LSIZE-1:0] l);
        return (l == '0) ? LSIZE'(1) : l;
    endfunction

    function automatic logic [LSIZE-1:0] sat_inc(input logic [LSIZE-1:0] c);
        return (c == CNT_MAX) ? c : c + LSIZE'(1);
    endfunction

    logic [CW-1:0]        ch;
    logic [LSIZE-1:0]     cnt;
    logic [NUM*LSIZE-1:0] len_q;
    logic [NUM*LSIZE-1:0] eff_len;
    logic [LSIZE-1:0]     seg_len [NUM];
    logic                 first;
    logic                 acc;
    logic                 seg_end;

    // A packet starts whenever the pointer is back at channel 0 with an empty count;
    // only then are the live lengths used, afterwards the latched copy.
    assign first   = (ch == '0) && (cnt == '0);
    assign eff_len = first ? split_len : len_q;

    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            seg_len[i] = norm_len(eff_len[i*LSIZE +: LSIZE]);
        end
    end

    assign seg_end       = (ch != LAST_CH) && (cnt == seg_len[ch] - LSIZE'(1));
    assign origin_tready = out_tready[ch];
    assign acc           = origin_tvalid & origin_tready;

    assign out_tdata = {NUM{origin_tdata}};
    assign out_tkeep = {NUM{origin_tkeep}};
    assign out_tuser = {NUM{origin_tuser}};

    always_comb begin
        out_tvalid     = '0;
        out_tlast      = '0;
        out_tvalid[ch] = origin_tvalid & aresetn;
        out_tlast[ch]  = origin_tlast | seg_end;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ch        <= '0;
            cnt       <= '0;
            len_q     <= '0;
            short_pkt <= 1'b0;
        end else begin
            short_pkt <= 1'b0;
            if (acc) begin
                if (first) begin
                    len_q <= split_len;
                end
                // Packet end wins over a coincident segment end: one tlast, restart at ch 0.
                if (origin_tlast) begin
                    ch        <= '0;
                    cnt       <= '0;
                    short_pkt <= (ch != LAST_CH);
                end else if (seg_end) begin
                    ch  <= ch + CW'(1);
                    cnt <= '0;
                end else begin
                    cnt <= sat_inc(cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_split_multi_channel.sv
// Randomized bench for axi_stream_split_multi_channel (NUM=3) with a beat-index
// reference model plus literal per-packet channel/tlast expectations.
module tb_axi_stream_split_multi_channel;

    localparam int NUM = 3, DSIZE = 8, KSIZE = 1, USIZE = 1, LSIZE = 16;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [NUM*LSIZE-1:0] split_len;
    logic [DSIZE-1:0]     origin_tdata;
    logic [KSIZE-1:0]     origin_tkeep;
    logic [USIZE-1:0]     origin_tuser;
    logic                 origin_tvalid;
    logic                 origin_tlast;
    logic                 origin_tready;
    logic [NUM*DSIZE-1:0] out_tdata;
    logic [NUM*KSIZE-1:0] out_tkeep;
    logic [NUM*USIZE-1:0] out_tuser;
    logic [NUM-1:0]       out_tvalid;
    logic [NUM-1:0]       out_tlast;
    logic [NUM-1:0]       out_tready;
    logic                 short_pkt;

    axi_stream_split_multi_channel #(
        .NUM(NUM), .DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE), .LSIZE(LSIZE)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .split_len(split_len),
        .origin_tdata(origin_tdata), .origin_tkeep(origin_tkeep), .origin_tuser(origin_tuser),
        .origin_tvalid(origin_tvalid), .origin_tlast(origin_tlast), .origin_tready(origin_tready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tuser(out_tuser),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
        .short_pkt(short_pkt)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int nl(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic logic [NUM*LSIZE-1:0] mk(input int a, input int b);
        return {16'd0, 16'(b), 16'(a)};
    endfunction

    // Reference model: beat index within packet plus lengths captured at the first beat.
    int           k = 0;
    int           l0 = 1, l1 = 1;
    bit           pend = 1'b0;
    int           short_cnt = 0;
    logic [2:0]   obs_v[$];
    logic [2:0]   obs_l[$];

    always @(negedge aclk) begin : model_p
        int c0, c1, ech;
        bit se;
        logic [2:0] ev, el;
        if (!aresetn) begin
            check("rst_tvalid", out_tvalid, 3'b000);
            check("rst_short", short_pkt, 1'b0);
            k = 0;
            pend = 1'b0;
        end else begin
            check("short_pkt", short_pkt, pend);
            if (short_pkt) short_cnt++;
            pend = 1'b0;
            if (k == 0) begin
                c0 = nl(int'(split_len[15:0]));
                c1 = nl(int'(split_len[31:16]));
            end else begin
                c0 = l0;
                c1 = l1;
            end
            if (k < c0) begin
                ech = 0; se = (k == c0 - 1);
            end else if (k < c0 + c1) begin
                ech = 1; se = (k == c0 + c1 - 1);
            end else begin
                ech = 2; se = 1'b0;
            end
            ev = origin_tvalid ? 3'(1 << ech) : 3'b000;
            check("tvalid", out_tvalid, ev);
            check("tready", origin_tready, out_tready[ech]);
            if (origin_tvalid) begin
                el = (origin_tlast | se) ? ev : 3'b000;
                check("tlast", out_tlast, el);
                for (int i = 0; i < NUM; i++) begin
                    check("tdata", out_tdata[i*DSIZE +: DSIZE], origin_tdata);
                    check("tkeep", out_tkeep[i*KSIZE +: KSIZE], origin_tkeep);
                    check("tuser", out_tuser[i*USIZE +: USIZE], origin_tuser);
                end
                if (out_tready[ech]) begin
                    obs_v.push_back(out_tvalid);
                    obs_l.push_back(out_tlast);
                    if (k == 0) begin
                        l0 = c0;
                        l1 = c1;
                    end
                    if (origin_tlast) begin
                        pend = (ech != 2);
                        k = 0;
                    end else begin
                        k++;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        origin_tvalid = 1'b0;
        origin_tlast  = 1'b0;
        repeat (n) begin
            @(posedge aclk); #1;
        end
    endtask

    task automatic send_pkt(input int n, input int stall, input int chg,
                            input logic [NUM*LSIZE-1:0] new_len, input bit last);
        int waits;
        bit got;
        for (int i = 0; i < n; i++) begin
            if (i == chg) split_len = new_len;
            origin_tdata  = 8'($urandom);
            origin_tkeep  = 1'($urandom);
            origin_tuser  = 1'($urandom);
            origin_tvalid = 1'b1;
            origin_tlast  = last && (i == n - 1);
            waits = 0;
            do begin
                for (int b = 0; b < NUM; b++) out_tready[b] = ($urandom_range(0, 99) >= stall);
                @(negedge aclk);
                got = origin_tready;
                @(posedge aclk); #1;
                waits++;
            end while (!got && waits < 200);
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: beat %0d never accepted, ready %0b required 1", i, got);
            end
        end
        origin_tvalid = 1'b0;
        origin_tlast  = 1'b0;
        out_tready    = '1;
    endtask

    task automatic clear_log();
        obs_v.delete();
        obs_l.delete();
        short_cnt = 0;
    endtask

    // chs: expected channel digit per accepted beat; tls: '1' where tlast is expected.
    task automatic check_log(input string name, input string chs, input string tls, input int es);
        logic [2:0] ev;
        check({name, "_beats"}, obs_v.size(), chs.len());
        for (int i = 0; i < chs.len() && i < obs_v.size(); i++) begin
            ev = 3'(1 << (chs[i] - 8'h30));
            check({name, "_ch"}, obs_v[i], ev);
            check({name, "_last"}, obs_l[i], (tls[i] == 8'h31) ? ev : 3'b000);
        end
        check({name, "_short"}, short_cnt, es);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

    initial begin : stim
        aresetn       = 1'b0;
        split_len     = '0;
        origin_tdata  = '0;
        origin_tkeep  = '0;
        origin_tuser  = '0;
        origin_tvalid = 1'b1;
        origin_tlast  = 1'b0;
        out_tready    = '1;
        repeat (3) @(posedge aclk);
        #1;
        origin_tvalid = 1'b0;
        aresetn = 1'b1;
        idle(1);

        clear_log();
        split_len = mk(4, 2);
        send_pkt(10, 0, -1, '0, 1'b1);
        idle(3);
        check_log("p10", "0000112222", "0001010001", 0);

        clear_log();
        send_pkt(5, 0, -1, '0, 1'b1);
        idle(3);
        check_log("p5", "00001", "00011", 1);

        clear_log();
        split_len = mk(3, 3);
        send_pkt(6, 0, -1, '0, 1'b1);
        idle(3);
        check_log("p6", "000111", "001001", 1);

        clear_log();
        split_len = mk(4, 2);
        send_pkt(10, 30, 2, mk(1, 1), 1'b1);
        idle(2);
        check_log("chg_cur", "0000112222", "0001010001", 0);

        clear_log();
        send_pkt(4, 30, -1, '0, 1'b1);
        idle(2);
        check_log("chg_next", "0122", "1101", 0);

        clear_log();
        split_len = mk(0, 0);
        send_pkt(4, 30, -1, '0, 1'b1);
        idle(2);
        check_log("len0", "0122", "1101", 0);

        // Reset in the middle of channel 1, with a beat still offered.
        split_len = mk(2, 5);
        send_pkt(5, 0, -1, '0, 1'b0);
        origin_tvalid = 1'b1;
        aresetn = 1'b0;
        idle(0);
        origin_tvalid = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        origin_tvalid = 1'b0;
        aresetn = 1'b1;
        idle(1);
        clear_log();
        send_pkt(3, 0, -1, '0, 1'b1);
        idle(2);
        check_log("post_rst", "001", "011", 1);

        for (int p = 0; p < 50; p++) begin
            int n, chg;
            n = $urandom_range(1, 14);
            chg = $urandom_range(0, n);
            split_len = mk($urandom_range(0, 5), $urandom_range(0, 5));
            send_pkt(n, 30, chg, mk($urandom_range(0, 5), $urandom_range(0, 5)), 1'b1);
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
